shared_ram_arbiter: RTL and testbench

//  Initiator side of the shared 8-bit RAM: arbitrates NUM_MASTERS peripheral request ports round-robin
//  and drives one command per cycle into the single-port Memory (enable/write/read/address/data_in).

---
 rtl/shared_ram_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/shared_ram_arbiter.sv | 103 ++++++++++
 tb/tb_shared_ram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ram_pkg.sv
// Purpose: shared definitions for the shared 8-bit RAM initiator (widths, index width, command layout).
package shared_ram_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);

    // One Memory command: strobes followed by address and write data.
    typedef struct packed {
        logic                  en;
        logic                  wr;
        logic                  rd;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin picker over a request vector, plus the rotating priority pointer.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   i_req        eligible requests
//   o_grant_c    one-hot winner (combinational)
//   o_idx_c      winner index (combinational)
//   o_valid_c    a winner exists (combinational)
module rr_arbiter
    import shared_ram_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] i_req,
    output logic [NUM_MASTERS-1:0] o_grant_c,
    output logic [IDX_W-1:0]       o_idx_c,
    output logic                   o_valid_c
);

    logic [IDX_W-1:0] r_ptr;

    // First requester at or after the pointer, wrapping modulo NUM_MASTERS.
    always_comb begin : p_pick
        int unsigned j;
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        j         = 0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            j = (32'(r_ptr) + k) % NUM_MASTERS;
            for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                if ((m == j) && !o_valid_c && i_req[m]) begin
                    o_valid_c    = 1'b1;
                    o_grant_c[m] = 1'b1;
                    o_idx_c      = IDX_W'(m);
                end
            end
        end
    end

    // Pointer moves just past the winner; held when nobody wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_valid_c) begin
            r_ptr <= IDX_W'((32'(o_idx_c) + 32'd1) % NUM_MASTERS);
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Purpose: initiator side of the shared single-port RAM. Arbitrates the masters round-robin,
//          issues one registered command per cycle to Memory, and routes read data back.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   req/wr/addr/wdata per-master request, op, packed address and write data
//   gnt              one-hot 1-cycle accept pulse
//   rvalid, rdata    one-hot read-return strobe and shared read data
//   mem_*            command outputs to Memory and its registered data_out
module shared_ram_arbiter
    import shared_ram_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS-1:0]        wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
    output logic [NUM_MASTERS-1:0]        gnt,
    output logic [NUM_MASTERS-1:0]        rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_enable,
    output logic                          mem_write,
    output logic                          mem_read,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_data_in,
    input  logic [DATA_W-1:0]             mem_data_out
);

    logic [NUM_MASTERS-1:0] w_elig;
    logic [NUM_MASTERS-1:0] w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_valid;
    mem_cmd_t               w_next;

    mem_cmd_t               r_cmd;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic                   r_tag_rd;
    logic [IDX_W-1:0]       r_tag_idx;
    logic [NUM_MASTERS-1:0] r_rvalid;

    // A master is masked during its own grant cycle so a held req is not granted twice.
    assign w_elig = req & ~r_gnt;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_elig),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );

    // Next command: winner's fields, or an idle command that keeps address/data.
    always_comb begin
        w_next    = r_cmd;
        w_next.en = w_valid;
        w_next.wr = 1'b0;
        w_next.rd = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_next.wr   = wr[i];
                w_next.rd   = ~wr[i];
                w_next.addr = addr[i*ADDR_W +: ADDR_W];
                w_next.data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Command/grant register at E0; read tag decoded into rvalid at E1 when Memory returns data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd     <= '0;
            r_gnt     <= '0;
            r_tag_rd  <= 1'b0;
            r_tag_idx <= '0;
            r_rvalid  <= '0;
        end else begin
            r_cmd     <= w_next;
            r_gnt     <= w_grant;
            r_tag_rd  <= w_next.rd;
            r_tag_idx <= w_idx;
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                r_rvalid[i] <= r_tag_rd && (32'(r_tag_idx) == i);
            end
        end
    end

    assign gnt         = r_gnt;
    assign rvalid      = r_rvalid;
    assign rdata       = mem_data_out;
    assign mem_enable  = r_cmd.en;
    assign mem_write   = r_cmd.wr;
    assign mem_read    = r_cmd.rd;
    assign mem_address = r_cmd.addr;
    assign mem_data_in = r_cmd.data;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Purpose: directed bench for shared_ram_arbiter with a behavioural single-port Memory.
module tb_shared_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        mem_enable;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;

    logic [7:0]  mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural Memory: executes the registered command, data_out registered.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_write) mem[mem_address] <= mem_data_in;
            if (mem_read)  mem_data_out     <= mem[mem_address];
        end
    end

    shared_ram_arbiter #(
        .NUM_MASTERS (4),
        .ADDR_W      (8),
        .DATA_W      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_enable   (mem_enable),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic w, input logic [7:0] a, input logic [7:0] d);
        req[m]          = 1'b1;
        wr[m]           = w;
        addr[m*8 +: 8]  = a;
        wdata[m*8 +: 8] = d;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gnt"},    32'(gnt),         32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid),      32'h0);
        chk({tag, "_en"},     32'(mem_enable),  32'h0);
        chk({tag, "_wr"},     32'(mem_write),   32'h0);
        chk({tag, "_rd"},     32'(mem_read),    32'h0);
        chk({tag, "_addr"},   32'(mem_address), 32'h0);
        chk({tag, "_din"},    32'(mem_data_in), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        chk_reset_state("rst0");
        reset = 1'b0;

        // 1: M0 write 0x12<-0xA5, then read it back
        set_m(0, 1'b1, 8'h12, 8'hA5);
        step();
        chk("t1_wr_gnt",  32'(gnt),         32'h1);
        chk("t1_wr_en",   32'(mem_enable),  32'h1);
        chk("t1_wr_wr",   32'(mem_write),   32'h1);
        chk("t1_wr_rd",   32'(mem_read),    32'h0);
        chk("t1_wr_addr", 32'(mem_address), 32'h12);
        chk("t1_wr_din",  32'(mem_data_in), 32'hA5);
        set_m(0, 1'b0, 8'h12, 8'h00);
        step();
        chk("t1_mask_gnt",  32'(gnt),         32'h0);
        chk("t1_mask_en",   32'(mem_enable),  32'h0);
        chk("t1_hold_addr", 32'(mem_address), 32'h12);
        chk("t1_hold_din",  32'(mem_data_in), 32'hA5);
        step();
        chk("t1_rd_gnt",  32'(gnt),      32'h1);
        chk("t1_rd_rd",   32'(mem_read), 32'h1);
        req[0] = 1'b0;
        step();
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_rdata",  32'(rdata),  32'hA5);

        // 2: four writes then four simultaneous reads, grant order 0..3
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_m(i, 1'b1, 8'h20 + 8'(i), 8'h80 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_wr_gnt", 32'(gnt), 32'(1) << i);
            req[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) set_m(i, 1'b0, 8'h20 + 8'(i), 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_rd_gnt", 32'(gnt), 32'(1) << i);
            chk("t2_rvalid", 32'(rvalid), (i == 0) ? 32'h0 : (32'(1) << (i - 1)));
            if (i > 0) chk("t2_rdata", 32'(rdata), 32'h80 + 32'(i - 1));
            req[i] = 1'b0;
        end
        step();
        chk("t2_rvalid3", 32'(rvalid), 32'h8);
        chk("t2_rdata3",  32'(rdata),  32'h83);
        chk("t2_gnt_end", 32'(gnt),    32'h0);

        // 3: ptr=2 with req=0011 held -> 0,1,0,1
        set_m(1, 1'b1, 8'h60, 8'h11);
        step();
        chk("t3_pre_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        set_m(0, 1'b1, 8'h61, 8'h21);
        set_m(1, 1'b1, 8'h62, 8'h22);
        step();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        chk("t3_adr0", 32'(mem_address), 32'h61);
        step();
        chk("t3_gnt1", 32'(gnt), 32'h2);
        chk("t3_adr1", 32'(mem_address), 32'h62);
        step();
        chk("t3_gnt2", 32'(gnt), 32'h1);
        step();
        chk("t3_gnt3", 32'(gnt), 32'h2);
        req = '0;

        // 4: same-cycle M1 write and M2 read of 0x40
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("rst4");
        set_m(1, 1'b1, 8'h40, 8'h3C);
        set_m(2, 1'b0, 8'h40, 8'h00);
        step();
        chk("t4_gnt_m1", 32'(gnt),       32'h2);
        chk("t4_wr",     32'(mem_write), 32'h1);
        req[1] = 1'b0;
        step();
        chk("t4_gnt_m2", 32'(gnt),         32'h4);
        chk("t4_rd",     32'(mem_read),    32'h1);
        chk("t4_addr",   32'(mem_address), 32'h40);
        req[2] = 1'b0;
        step();
        chk("t4_rvalid", 32'(rvalid), 32'h4);
        chk("t4_rdata",  32'(rdata),  32'h3C);

        // 5: reset right after a read grant kills the response
        set_m(0, 1'b0, 8'h12, 8'h00);
        step();
        chk("t5_gnt", 32'(gnt),      32'h1);
        chk("t5_rd",  32'(mem_read), 32'h1);
        req   = '0;
        reset = 1'b1;
        step();
        chk_reset_state("rst5");
        reset = 1'b0;
        step();
        chk("t5_no_rvalid0", 32'(rvalid), 32'h0);
        step();
        chk("t5_no_rvalid1", 32'(rvalid), 32'h0);
        set_m(3, 1'b0, 8'h23, 8'h00);
        step();
        chk("t5_m3_gnt", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        step();
        chk("t5_m3_rvalid", 32'(rvalid), 32'h8);
        chk("t5_m3_rdata",  32'(rdata),  32'h83);

        // 6: idle for 10 cycles holds the pointer (left at 2)
        set_m(1, 1'b1, 8'h70, 8'h77);
        step();
        chk("t6_pre_gnt", 32'(gnt), 32'h2);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_idle_en",     32'(mem_enable), 32'h0);
            chk("t6_idle_gnt",    32'(gnt),        32'h0);
            chk("t6_idle_rvalid", 32'(rvalid),     32'h0);
        end
        set_m(0, 1'b1, 8'h71, 8'h01);
        set_m(1, 1'b1, 8'h72, 8'h02);
        set_m(3, 1'b1, 8'h73, 8'h03);
        step();
        chk("t6_gnt_m3", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        step();
        chk("t6_gnt_m0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        step();
        chk("t6_gnt_m1", 32'(gnt), 32'h2);
        req = '0;
        step();
        chk("t6_gnt_end", 32'(gnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
